// File: rtl/keyboard_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_tracker_pkg
//  Description : Scan-code constants, key indices and decoder state type
//                shared by the PS/2 keyboard tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package keyboard_tracker_pkg;

    localparam logic [7:0] KEY_S        = 8'h1B;
    localparam logic [7:0] KEY_R        = 8'h2D;
    localparam logic [7:0] KEY_D        = 8'h23;
    localparam logic [7:0] KEY_C        = 8'h21;
    localparam logic [7:0] KEY_ENTER    = 8'h5A;
    localparam logic [7:0] KEY_SPACE    = 8'h29;
    localparam logic [7:0] PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PREFIX_EXT   = 8'hE0;

    localparam int NUM_KEYS   = 6;
    localparam int FRAME_BITS = 11;

    localparam int IDX_S     = 0;
    localparam int IDX_R     = 1;
    localparam int IDX_D     = 2;
    localparam int IDX_C     = 3;
    localparam int IDX_ENTER = 4;
    localparam int IDX_SPACE = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } dec_state_e;

    // One-hot key select; under the E0 prefix only Enter is recognised.
    function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code,
                                                      input logic       ext);
        key_mask = '0;
        if (ext) begin
            if (code == KEY_ENTER) key_mask[IDX_ENTER] = 1'b1;
        end else begin
            case (code)
                KEY_S:     key_mask[IDX_S]     = 1'b1;
                KEY_R:     key_mask[IDX_R]     = 1'b1;
                KEY_D:     key_mask[IDX_D]     = 1'b1;
                KEY_C:     key_mask[IDX_C]     = 1'b1;
                KEY_ENTER: key_mask[IDX_ENTER] = 1'b1;
                KEY_SPACE: key_mask[IDX_SPACE] = 1'b1;
                default:   key_mask = '0;
            endcase
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/keyboard_tracker_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_byte
//  Description : PS/2 device-to-host frame receiver with synchronisers,
//                falling-edge sampling, idle timeout and framing checks.
//                Parity is enforced when KEYBOARD_TRACKER_PARITY_CHECK_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_byte
    import keyboard_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
`ifdef KEYBOARD_TRACKER_PARITY_CHECK_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    logic [1:0]            clk_sync_q;
    logic [1:0]            dat_sync_q;
    logic                  clk_prev_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [3:0]            bit_cnt_q;
    logic [TW-1:0]         idle_cnt_q;
    logic [7:0]            byte_q;
    logic                  valid_q;

    logic                  fall;
    logic [FRAME_BITS-1:0] frame;
    logic                  frame_ok;

    assign fall  = clk_prev_q & ~clk_sync_q[1];
    assign frame = {dat_sync_q[1], shift_q[FRAME_BITS-1:1]};

    // frame[0]=start, frame[8:1]=data LSB first, frame[9]=parity, frame[10]=stop
    always_comb begin
        frame_ok = ~frame[0] & frame[10] & ((^frame[9:1]) | ~PARITY_EN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
            valid_q    <= 1'b0;
            if (fall) begin
                idle_cnt_q <= '0;
                shift_q    <= frame;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q <= '0;
                    valid_q   <= frame_ok;
                    if (frame_ok) byte_q <= frame[8:1];
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (idle_cnt_q == TO_LAST) begin
                    bit_cnt_q  <= '0;
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + TW'(1);
                end
            end
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/keyboard_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_tracker
//  Description : PS/2 scan-code set 2 tracker producing hold or pulse flags
//                for s, r, d, c, Enter and Space. Optional parity checking
//                via KEYBOARD_TRACKER_PARITY_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module keyboard_tracker
    import keyboard_tracker_pkg::*;
#(
    parameter int PULSE_OR_HOLD  = 0,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    inout  wire  PS2_CLK,
    inout  wire  PS2_DAT,
    output logic s,
    output logic r,
    output logic d,
    output logic c,
    output logic enter,
    output logic space
);

    localparam logic PULSE_MODE = (PULSE_OR_HOLD != 0);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    dec_state_e          state_q;
    logic [NUM_KEYS-1:0] hold_q;
    logic [NUM_KEYS-1:0] flags_q;
    logic [NUM_KEYS-1:0] code_mask;
    logic [NUM_KEYS-1:0] make_mask;
    logic [NUM_KEYS-1:0] break_mask;
    logic [NUM_KEYS-1:0] hold_d;
    logic [NUM_KEYS-1:0] pulse_d;

    ps2_rx_byte #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i        (clock),
        .rst_ni       (reset),
        .ps2_clk_i    (PS2_CLK),
        .ps2_dat_i    (PS2_DAT),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid)
    );

    // Prefix bytes never match a tracked code, so they fall out of the masks.
    always_comb begin
        code_mask  = key_mask(rx_byte, (state_q == ST_EXT) || (state_q == ST_EXT_BREAK));
        make_mask  = '0;
        break_mask = '0;
        if (rx_valid) begin
            if ((state_q == ST_IDLE) || (state_q == ST_EXT)) make_mask  = code_mask;
            else                                             break_mask = code_mask;
        end
        hold_d  = (hold_q | make_mask) & ~break_mask;
        pulse_d = make_mask & ~hold_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            flags_q <= '0;
        end else begin
            hold_q  <= hold_d;
            flags_q <= PULSE_MODE ? pulse_d : hold_d;
            if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_byte == PREFIX_BREAK)    state_q <= ST_BREAK;
                        else if (rx_byte == PREFIX_EXT) state_q <= ST_EXT;
                        else                            state_q <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (rx_byte == PREFIX_BREAK) state_q <= ST_EXT_BREAK;
                        else                         state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign s     = flags_q[IDX_S];
    assign r     = flags_q[IDX_R];
    assign d     = flags_q[IDX_D];
    assign c     = flags_q[IDX_C];
    assign enter = flags_q[IDX_ENTER];
    assign space = flags_q[IDX_SPACE];

endmodule
`default_nettype wire

// File: tb/tb_keyboard_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keyboard_tracker
//  Description : Directed bench driving one PS/2 line pair into a hold-mode
//                and a pulse-mode tracker; flag bits {space,enter,c,d,r,s}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_tracker;

    localparam int HALF = 10;

    logic clock       = 1'b0;
    logic reset       = 1'b0;
    logic ps2_clk_drv = 1'b1;
    logic ps2_dat_drv = 1'b1;
    wire  ps2_clk;
    wire  ps2_dat;
    wire  [5:0] hf;
    wire  [5:0] pf;

    assign ps2_clk = ps2_clk_drv;
    assign ps2_dat = ps2_dat_drv;

    int total = 0;
    int bad   = 0;
    int pcnt [6];
    int base;

    keyboard_tracker #(.PULSE_OR_HOLD(0)) u_hold (
        .clock (clock), .reset (reset), .PS2_CLK (ps2_clk), .PS2_DAT (ps2_dat),
        .s (hf[0]), .r (hf[1]), .d (hf[2]), .c (hf[3]), .enter (hf[4]), .space (hf[5])
    );

    keyboard_tracker #(.PULSE_OR_HOLD(1)) u_pulse (
        .clock (clock), .reset (reset), .PS2_CLK (ps2_clk), .PS2_DAT (ps2_dat),
        .s (pf[0]), .r (pf[1]), .d (pf[2]), .c (pf[3]), .enter (pf[4]), .space (pf[5])
    );

    always #10 clock = ~clock;

    initial for (int i = 0; i < 6; i++) pcnt[i] = 0;

    always @(posedge clock) begin
        for (int k = 0; k < 6; k++) if (pf[k] === 1'b1) pcnt[k] <= pcnt[k] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat_drv = b;
        repeat (HALF) @(posedge clock);
        ps2_clk_drv = 1'b0;
        repeat (HALF) @(posedge clock);
        ps2_clk_drv = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(bad_par ? ^b : ~^b);
        ps2_bit(1'b1);
        repeat (HALF) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    initial begin
        logic [31:0] exp_par;
        // Reset state
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_hold", {26'd0, hf}, 32'h0);
        check("rst_pulse", {26'd0, pf}, 32'h0);
        reset = 1'b1;
        repeat (5) @(posedge clock);

        // Reset in the middle of a frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("midrst_hold", {26'd0, hf}, 32'h0);
        reset = 1'b1;
        repeat (10) @(posedge clock);

        // Hold mode make/break of S, pulse of S
        base = pcnt[0];
        send(8'h1B);
        check("make_s", {26'd0, hf}, 32'h01);
        check("pulse_s", pcnt[0] - base, 32'd1);
        check("pulse_idle", {26'd0, pf}, 32'h0);
        send(8'hF0); send(8'h1B);
        check("break_s", {26'd0, hf}, 32'h0);

        // Space typematic repeats
        base = pcnt[5];
        send(8'h29); send(8'h29); send(8'h29);
        check("hold_space", {26'd0, hf}, 32'h20);
        check("pulse_space", pcnt[5] - base, 32'd1);
        send(8'hF0); send(8'h29);
        check("break_space", {26'd0, hf}, 32'h0);
        check("pulse_space_once", pcnt[5] - base, 32'd1);

        // Extended codes
        base = pcnt[4];
        send(8'hE0); send(8'h5A);
        check("ext_enter", {26'd0, hf}, 32'h10);
        check("pulse_enter", pcnt[4] - base, 32'd1);
        send(8'hE0); send(8'hF0); send(8'h5A);
        check("ext_break_enter", {26'd0, hf}, 32'h0);
        send(8'hE0); send(8'h1B);
        check("ext_s_ignored", {26'd0, hf}, 32'h0);

        // Wrong parity on R
`ifdef KEYBOARD_TRACKER_PARITY_CHECK_EN
        exp_par = 32'h0;
`else
        exp_par = 32'h2;
`endif
        send_byte(8'h2D, 1'b1);
        check("parity_r", {26'd0, hf}, exp_par);
        send(8'hF0); send(8'h2D);
        check("break_r", {26'd0, hf}, 32'h0);

        // Several keys held at once
        send(8'h23); send(8'h21);
        check("multi_dc", {26'd0, hf}, 32'h0C);
        send(8'hF0); send(8'h23);
        check("release_d", {26'd0, hf}, 32'h08);
        send(8'hF0); send(8'h21);
        check("release_c", {26'd0, hf}, 32'h0);

        // Untracked code
        send(8'h1C);
        check("untracked", {26'd0, hf}, 32'h0);
        send(8'hF0); send(8'h1C);

        // Timeout drops a partial frame
        base = pcnt[3];
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b1);
        repeat (50010) @(posedge clock);
        send(8'h21);
        check("timeout_c", {26'd0, hf}, 32'h08);
        check("timeout_pulse_c", pcnt[3] - base, 32'd1);
        send(8'hF0); send(8'h21);
        check("timeout_break_c", {26'd0, hf}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
